chacha_block_core: RTL

Parametrised successor to the single-lane quarter-round engine. Takes key/nonce/counter plus a block count and produces a stream of ChaCha keystream blocks (constants load, ROUNDS rounds, feed-forward add), with valid/ready handshakes on both sides. Quarter-round parallelism is configurable. Sits between the AEAD controller and the Poly1305 key and XOR datapath.

---
 rtl/chacha_pkg.sv | 37 +++
 rtl/chacha_block_core_if.sv | 38 +++
 rtl/chacha_qround.sv | 25 ++
 rtl/chacha_block_core.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha block core.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] state_t;
    // Word indices of one quarter-round, [0]=a .. [3]=d.
    typedef logic [3:0][3:0] qr_idx_t;

    typedef enum logic [2:0] {StIdle, StLoad, StRound, StFinal, StHold} fsm_t;

    localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Steps 0..3 are column quarter-rounds, 4..7 the diagonal ones.
    function automatic qr_idx_t qr_index(input logic [2:0] round_step, input logic [2:0] lane);
        logic [2:0] q;
        logic [1:0] i;
        qr_idx_t    r;
        q    = round_step + lane;
        i    = q[1:0];
        r[0] = {2'b00, i};
        if (!q[2]) begin
            r[1] = {2'b01, i};
            r[2] = {2'b10, i};
            r[3] = {2'b11, i};
        end else begin
            r[1] = {2'b01, i + 2'd1};
            r[2] = {2'b10, i + 2'd2};
            r[3] = {2'b11, i + 2'd3};
        end
        return r;
    endfunction

endpackage

// File: rtl/chacha_block_core_if.sv
// Request/response bundle of the ChaCha block core; hchacha_i exists only with CHACHA_HCHACHA_EN.
interface chacha_block_core_if
    import chacha_pkg::*;
#(
    parameter int unsigned NB_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [255:0]    key_i;
    logic [95:0]     nonce_i;
    word_t           counter_i;
    logic [NB_W-1:0] nblocks_i;
`ifdef CHACHA_HCHACHA_EN
    logic            hchacha_i;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [511:0]    block_o;
    logic            last_o;
    logic            ctr_wrap_o;

    modport master (
        output in_valid, key_i, nonce_i, counter_i, nblocks_i, out_ready,
`ifdef CHACHA_HCHACHA_EN
        output hchacha_i,
`endif
        input  in_ready, out_valid, block_o, last_o, ctr_wrap_o
    );

    modport slave (
        input  in_valid, key_i, nonce_i, counter_i, nblocks_i, out_ready,
`ifdef CHACHA_HCHACHA_EN
        input  hchacha_i,
`endif
        output in_ready, out_valid, block_o, last_o, ctr_wrap_o
    );

endinterface

// File: rtl/chacha_qround.sv
// Combinational ChaCha quarter-round.
module chacha_qround
    import chacha_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_nxt,
    output word_t b_nxt,
    output word_t c_nxt,
    output word_t d_nxt
);
    word_t a1, b1, c1, d1;

    assign a1    = a + b;
    assign d1    = rotl(d ^ a1, 16);
    assign c1    = c + d1;
    assign b1    = rotl(b ^ c1, 12);
    assign a_nxt = a1 + b1;
    assign d_nxt = rotl(d1 ^ a_nxt, 8);
    assign c_nxt = c1 + d_nxt;
    assign b_nxt = rotl(b1 ^ c_nxt, 7);

endmodule

// File: rtl/chacha_block_core.sv
// ChaCha keystream block generator with QR_LANES quarter-rounds per cycle.
// Optional HChaCha output mode is built in when CHACHA_HCHACHA_EN is defined.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int unsigned ROUNDS   = 20,
    parameter int unsigned QR_LANES = 1,
    parameter int unsigned NB_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    chacha_block_core_if.slave bus
);
    localparam int unsigned RoundCycles = ROUNDS * 4 / QR_LANES;
    localparam int unsigned RcW         = $clog2(RoundCycles);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_LANES == 1 || QR_LANES == 2 || QR_LANES == 4)) begin : g_bad_lanes
        $error("chacha_block_core: QR_LANES must be 1, 2 or 4");
    end

    fsm_t            state_q;
    state_t          init_q, work_q, block_q;
    state_t          work_nxt, assembled, final_blk;
    logic [255:0]    key_q;
    logic [95:0]     nonce_q;
    word_t           ctr_q;
    logic [NB_W-1:0] remaining_q;
    logic [RcW-1:0]  rnd_q;
    logic [2:0]      step_q;
    logic            in_ready_q, out_valid_q, last_q, wrap_q;
`ifdef CHACHA_HCHACHA_EN
    logic            hc_q;
`endif

    qr_idx_t lane_idx [QR_LANES];
    word_t   qa [QR_LANES], qb [QR_LANES], qc [QR_LANES], qd [QR_LANES];
    word_t   na [QR_LANES], nb [QR_LANES], nc [QR_LANES], nd [QR_LANES];

    for (genvar l = 0; l < QR_LANES; l++) begin : g_lane
        chacha_qround u_qround (
            .a(qa[l]), .b(qb[l]), .c(qc[l]), .d(qd[l]),
            .a_nxt(na[l]), .b_nxt(nb[l]), .c_nxt(nc[l]), .d_nxt(nd[l])
        );
    end

    always_comb begin
        for (int l = 0; l < QR_LANES; l++) begin
            lane_idx[l] = qr_index(step_q, 3'(l));
            qa[l]       = work_q[lane_idx[l][0]];
            qb[l]       = work_q[lane_idx[l][1]];
            qc[l]       = work_q[lane_idx[l][2]];
            qd[l]       = work_q[lane_idx[l][3]];
        end
    end

    // Lanes always touch disjoint words, so write-back order does not matter.
    always_comb begin
        work_nxt = work_q;
        for (int l = 0; l < QR_LANES; l++) begin
            work_nxt[lane_idx[l][0]] = na[l];
            work_nxt[lane_idx[l][1]] = nb[l];
            work_nxt[lane_idx[l][2]] = nc[l];
            work_nxt[lane_idx[l][3]] = nd[l];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) assembled[i] = SIGMA[i];
        for (int i = 0; i < 8; i++) assembled[4+i] = key_q[32*i +: 32];
        assembled[12] = ctr_q;
        for (int i = 0; i < 3; i++) assembled[13+i] = nonce_q[32*i +: 32];
    end

    always_comb begin
        for (int i = 0; i < 16; i++) final_blk[i] = work_q[i] + init_q[i];
`ifdef CHACHA_HCHACHA_EN
        if (hc_q) begin
            final_blk = '0;
            for (int i = 0; i < 4; i++) begin
                final_blk[i]   = work_q[i];
                final_blk[4+i] = work_q[12+i];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            init_q      <= '0;
            work_q      <= '0;
            block_q     <= '0;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            remaining_q <= '0;
            rnd_q       <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef CHACHA_HCHACHA_EN
            hc_q        <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        key_q       <= bus.key_i;
                        nonce_q     <= bus.nonce_i;
                        ctr_q       <= bus.counter_i;
                        remaining_q <= (bus.nblocks_i == '0) ? NB_W'(1) : bus.nblocks_i;
`ifdef CHACHA_HCHACHA_EN
                        hc_q        <= bus.hchacha_i;
                        if (bus.hchacha_i) remaining_q <= NB_W'(1);
`endif
                        in_ready_q  <= 1'b0;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    init_q  <= assembled;
                    work_q  <= assembled;
                    rnd_q   <= '0;
                    step_q  <= '0;
                    state_q <= StRound;
                end
                StRound: begin
                    work_q <= work_nxt;
                    step_q <= step_q + 3'(QR_LANES);
                    if (rnd_q == RcW'(RoundCycles - 1)) state_q <= StFinal;
                    else rnd_q <= rnd_q + 1'b1;
                end
                StFinal: begin
                    block_q     <= final_blk;
                    out_valid_q <= 1'b1;
                    last_q      <= (remaining_q == NB_W'(1));
                    state_q     <= StHold;
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        last_q      <= 1'b0;
                        if (remaining_q == NB_W'(1)) begin
                            in_ready_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            remaining_q <= remaining_q - NB_W'(1);
                            ctr_q       <= ctr_q + 32'd1;
                            wrap_q      <= (ctr_q == 32'hffff_ffff);
                            state_q     <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.block_o    = block_q;
    assign bus.last_o     = last_q;
    assign bus.ctr_wrap_o = wrap_q;

endmodule
